// File: rtl/t03_pc_pkg.sv
// Shared encodings and default vectors for the team 03 PC/fetch front end.
package t03_pc_pkg;

  typedef enum logic [2:0] {
    CTRL_SEQ    = 3'd0,
    CTRL_JALR   = 3'd1,
    CTRL_BRANCH = 3'd2,
    CTRL_JAL    = 3'd3,
    CTRL_MRET   = 3'd4
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDRESS = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/t03_pc_target.sv
// Next-PC selection: trap first, then misaligned control transfer, then ctrl mux.
module t03_pc_target
  import t03_pc_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEF_TRAP_VECTOR)
) (
  input  logic            trap,
  input  logic [2:0]      ctrl,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] target,
  output logic            take_trap,
  output logic            misalign
);

  logic [XLEN-1:0] raw;
  logic            checked;

  always_comb begin
    raw     = pc + XLEN'(4);
    checked = 1'b0;
    case (ctrl)
      CTRL_JALR: begin
        raw     = alu_result & ~XLEN'(1);
        checked = 1'b1;
      end
      CTRL_BRANCH, CTRL_JAL: begin
        raw     = pc + offset;
        checked = 1'b1;
      end
      CTRL_MRET: raw = mepc;
      default:   raw = pc + XLEN'(4);
    endcase
  end

  assign misalign  = !trap && checked && raw[1];
  assign take_trap = trap || misalign;
  assign target    = take_trap ? TRAP_VECTOR : raw;

endmodule

// File: rtl/t03_pc_fetch.sv
// PC register, single-outstanding fetch FSM, stale-fetch discard and instruction buffer.
module t03_pc_fetch
  import t03_pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] BASE_ADDRESS = XLEN'(DEF_BASE_ADDRESS),
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            retire,
  input  logic [2:0]      ctrl,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] alu_result,
  input  logic            trap,
  output logic            fetch_req,
  output logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_ack,
  input  logic [XLEN-1:0] fetch_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] mepc,
  output logic            misalign
);

  state_e          state_q;
  logic [XLEN-1:0] pc_q, mepc_q, addr_q, instr_q, ipc_q;
  logic            stale_q, mis_q;

  logic [XLEN-1:0] target, next_pc;
  logic            take_trap, tgt_mis, update;

  t03_pc_target #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_target (
    .trap       (trap),
    .ctrl       (ctrl),
    .pc         (pc_q),
    .mepc       (mepc_q),
    .offset     (offset),
    .alu_result (alu_result),
    .target     (target),
    .take_trap  (take_trap),
    .misalign   (tgt_mis)
  );

  assign update  = !freeze && state_q != ST_IDLE &&
                   (trap || (retire && state_q == ST_HOLD));
  assign next_pc = update ? target : pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VECTOR;
      mepc_q  <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      stale_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= update && tgt_mis;
      if (update) begin
        pc_q <= target;
        if (take_trap) mepc_q <= pc_q;
      end
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          addr_q  <= pc_q + BASE_ADDRESS;
        end
        ST_FETCH: begin
          // An ack coinciding with a trap is treated as stale too: its PC is already superseded.
          if (fetch_ack) begin
            if (stale_q || update) begin
              addr_q  <= next_pc + BASE_ADDRESS;
              stale_q <= 1'b0;
            end else begin
              instr_q <= fetch_data;
              ipc_q   <= pc_q;
              state_q <= ST_HOLD;
            end
          end else if (update) begin
            stale_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (update) begin
            state_q <= ST_FETCH;
            addr_q  <= target + BASE_ADDRESS;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fetch_req   = state_q == ST_FETCH;
  assign fetch_addr  = addr_q;
  assign instr_valid = state_q == ST_HOLD;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign pc          = pc_q;
  assign mepc        = mepc_q;
  assign misalign    = mis_q;

endmodule

// File: tb/tb_t03_pc_fetch.sv
// Bench for t03_pc_fetch: directed walk of the main scenarios, then random traffic vs a transaction model.
module tb_t03_pc_fetch;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] TV   = 32'h0000_0100;

  logic        clk = 1'b0, rst = 1'b1;
  logic        freeze = 1'b0, retire = 1'b0, trap = 1'b0, fetch_ack = 1'b0;
  logic [2:0]  ctrl = '0;
  logic [31:0] offset = '0, alu_result = '0, fetch_data = '0;
  logic        fetch_req, instr_valid, misalign;
  logic [31:0] fetch_addr, instr, instr_pc, pc, mepc;

  int unsigned n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  t03_pc_fetch #(
    .XLEN         (32),
    .BASE_ADDRESS (BASE),
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV)
  ) dut (
    .clk (clk), .rst (rst), .freeze (freeze), .retire (retire), .ctrl (ctrl),
    .offset (offset), .alu_result (alu_result), .trap (trap),
    .fetch_req (fetch_req), .fetch_addr (fetch_addr), .fetch_ack (fetch_ack),
    .fetch_data (fetch_data), .instr_valid (instr_valid), .instr (instr),
    .instr_pc (instr_pc), .pc (pc), .mepc (mepc), .misalign (misalign)
  );

  // Transaction-level model: booting, waiting on a fetch, or holding an instruction.
  logic        m_boot, m_have, m_stale, m_mis;
  logic [31:0] m_pc, m_mepc, m_addr, m_instr, m_ipc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_have = 1'b0; m_stale = 1'b0; m_mis = 1'b0;
    m_pc = RV; m_mepc = '0; m_addr = '0; m_instr = '0; m_ipc = '0;
  endtask

  task automatic compare_all();
    chk("fetch_req",   32'(fetch_req),   32'(!m_boot && !m_have));
    chk("fetch_addr",  fetch_addr,       m_addr);
    chk("instr_valid", 32'(instr_valid), 32'(m_have));
    chk("instr",       instr,            m_instr);
    chk("instr_pc",    instr_pc,         m_ipc);
    chk("pc",          pc,               m_pc);
    chk("mepc",        mepc,             m_mepc);
    chk("misalign",    32'(misalign),    32'(m_mis));
  endtask

  task automatic model_step(input logic fz, rt, tp, input logic [2:0] ct,
                            input logic [31:0] off, alu, input logic ak,
                            input logic [31:0] dat);
    logic        upd, to_trap, bad;
    logic [31:0] dest, np;
    if (m_boot) begin
      m_boot = 1'b0;
      m_addr = m_pc + BASE;
      m_mis  = 1'b0;
      return;
    end
    upd = !fz && (tp || (rt && m_have));
    bad = 1'b0;
    case (ct)
      3'd1:       begin dest = {alu[31:1], 1'b0}; bad = dest[1]; end
      3'd2, 3'd3: begin dest = m_pc + off;        bad = dest[1]; end
      3'd4:       dest = m_mepc;
      default:    dest = m_pc + 32'd4;
    endcase
    to_trap = tp || bad;
    np = !upd ? m_pc : (to_trap ? TV : dest);
    m_mis = upd && !tp && bad;
    if (!m_have) begin
      if (ak) begin
        if (m_stale || upd) begin
          m_addr = np + BASE; m_stale = 1'b0;
        end else begin
          m_instr = dat; m_ipc = m_pc; m_have = 1'b1;
        end
      end else if (upd) begin
        m_stale = 1'b1;
      end
    end else if (upd) begin
      m_have = 1'b0;
      m_addr = np + BASE;
    end
    if (upd && to_trap) m_mepc = m_pc;
    m_pc = np;
  endtask

  task automatic step(input logic fz, rt, tp, input logic [2:0] ct,
                      input logic [31:0] off, alu, input logic ak);
    logic [31:0] dat;
    dat = $urandom;
    freeze = fz; retire = rt; trap = tp; ctrl = ct;
    offset = off; alu_result = alu; fetch_ack = ak; fetch_data = dat;
    @(posedge clk);
    model_step(fz, rt, tp, ct, off, alu, ak, dat);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input logic ack_during);
    rst = 1'b1; fetch_ack = ack_during; retire = 1'b0; trap = 1'b0; freeze = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0; fetch_ack = 1'b0;
  endtask

  initial begin
    logic fz, rt, tp, ak;
    logic [2:0] ct;
    logic [31:0] off, alu;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset(1'b0);

    // Boot, then sequential fetches 0x1000, 0x1004, ... with zero-wait acks
    step(0, 0, 0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 3'd0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 3'd0, 0, 0, 0);
      step(0, 0, 0, 3'd0, 0, 0, 1);
    end
    chk("seq_pc", pc, 32'h10);
    step(0, 1, 0, 3'd2, 32'hFFFF_FFF8, 0, 0);
    chk("branch_addr", fetch_addr, 32'h1008);
    step(0, 0, 0, 3'd0, 0, 0, 1);
    step(0, 1, 0, 3'd1, 0, 32'h21, 0);
    chk("jalr_pc", pc, 32'h20);
    step(0, 0, 0, 3'd0, 0, 0, 1);
    step(0, 1, 0, 3'd1, 0, 32'h22, 0);
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_mepc", mepc, 32'h20);
    step(0, 0, 0, 3'd0, 0, 0, 1);
    step(0, 1, 0, 3'd4, 0, 0, 0);
    chk("mret_pc", pc, 32'h20);
    // Trap while the fetch is outstanding; ack arrives three cycles later
    step(0, 0, 1, 3'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 3'd0, 0, 0, 0);
    chk("trap_hold_addr", fetch_addr, 32'h1020);
    step(0, 0, 0, 3'd0, 0, 0, 1);
    chk("stale_dropped", 32'(instr_valid), 32'd0);
    chk("trap_refetch", fetch_addr, TV + BASE);
    step(0, 0, 0, 3'd0, 0, 0, 1);
    step(1, 1, 0, 3'd0, 0, 0, 0);
    step(1, 1, 0, 3'd0, 0, 0, 0);
    chk("freeze_pc", pc, 32'h100);
    step(0, 1, 0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 3'd0, 0, 0, 0);
    chk("unfreeze_pc", pc, 32'h104);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(299) == 0) begin
        do_reset(1'($urandom_range(1)));
        continue;
      end
      fz  = $urandom_range(99) < 15;
      rt  = $urandom_range(99) < 50;
      tp  = $urandom_range(99) < 5;
      ct  = 3'($urandom_range(7));
      off = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(15)) << 2;
      alu = $urandom_range(3) == 0 ? $urandom : 32'($urandom_range(255));
      ak  = !m_boot && !m_have && ($urandom_range(99) < 60);
      step(fz, rt, tp, ct, off, alu, ak);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
